// File: rtl/cpu_pkg.sv
// Shared RV32I control definitions: opcode constants, sequencer state encoding
// and the legal-opcode check used by the sequencer and the opcode decoder.
package cpu_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } seq_state_e;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LW, OP_S, OP_B, OP_JAL, OP_LUI, OP_AUIPC: return 1'b1;
            default:                                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Shared memory port between the sequencer (master) and the memory (slave).
interface cpu_sequencer_if;
    logic mem_req;
    logic mem_ready;
    logic mem_we;
    logic mem_is_fetch;

    modport master (output mem_req, output mem_we, output mem_is_fetch, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_is_fetch, output mem_ready);
endinterface

// File: rtl/cpu_sequencer_mem_wait_timer.sv
// Memory wait counter: counts stalled request cycles and flags the cycle whose
// edge would reach TIMEOUT_CYCLES. Used only when SEQ_TIMEOUT_EN is defined.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic i_ready,
    output logic o_expire
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST_WAIT = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] r_count;
    logic         w_waiting;

    assign w_waiting = i_req && !i_ready;

    // Count consecutive wait cycles; any idle or completing cycle starts over.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= {W{1'b0}};
        end else if (w_waiting) begin
            r_count <= r_count + W'(1'b1);
        end else begin
            r_count <= {W{1'b0}};
        end
    end

    // A ready on the limit cycle completes the request instead of expiring.
    assign o_expire = w_waiting && (r_count == LAST_WAIT);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Define SEQ_TIMEOUT_EN to trap memory requests that wait TIMEOUT_CYCLES.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [6:0]             opcode,
    input  logic                   dec_mem_read,
    input  logic                   dec_mem_write,
    input  logic                   dec_reg_write,
    input  logic                   stall,
    cpu_sequencer_if.master        mem,
    output logic                   ir_load,
    output logic                   pc_write,
    output logic                   rf_write,
    output logic                   retire,
    output logic                   error,
    output logic [2:0]             state
);
    seq_state_e r_state;
    logic       r_error;
    logic       r_wb_strobe;
    logic       r_mem_is_fetch;
    logic       r_fetch_pending;

    logic w_mem_req;
    logic w_mem_done;
    logic w_timeout;
    logic w_branch_done;
    logic w_store_done;

`ifdef SEQ_TIMEOUT_EN
    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_mem_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (w_mem_req),
        .i_ready  (mem.mem_ready),
        .o_expire (w_timeout)
    );
`else
    // No wait counter in this build: a request waits for mem_ready indefinitely.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // Stall only holds off a fetch not yet issued; an issued one stays up until accepted.
    assign w_mem_req     = ((r_state == ST_FETCH) && (!stall || r_fetch_pending)) ||
                           (r_state == ST_MEM);
    assign w_mem_done    = w_mem_req && mem.mem_ready;
    assign w_branch_done = (r_state == ST_EXEC) && !dec_mem_read && !dec_mem_write &&
                           !dec_reg_write;
    assign w_store_done  = (r_state == ST_MEM) && w_mem_done && dec_mem_write;

    // Sequencer state, sticky error and the registered WB/address-select outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= ST_RESET;
            r_error         <= 1'b0;
            r_wb_strobe     <= 1'b0;
            r_mem_is_fetch  <= 1'b1;
            r_fetch_pending <= 1'b0;
        end else begin
            r_wb_strobe    <= 1'b0;
            r_mem_is_fetch <= 1'b1;
            case (r_state)
                ST_RESET: begin
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (w_timeout) begin
                        r_state         <= ST_TRAP;
                        r_error         <= 1'b1;
                        r_fetch_pending <= 1'b0;
                    end else if (w_mem_done) begin
                        r_state         <= ST_DECODE;
                        r_fetch_pending <= 1'b0;
                    end else begin
                        r_fetch_pending <= w_mem_req;
                    end
                end
                ST_DECODE: begin
                    if (is_legal_opcode(opcode)) begin
                        r_state <= ST_EXEC;
                    end else begin
                        r_state <= ST_TRAP;
                        r_error <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (dec_mem_read || dec_mem_write) begin
                        r_state        <= ST_MEM;
                        r_mem_is_fetch <= 1'b0;
                    end else if (dec_reg_write) begin
                        r_state     <= ST_WB;
                        r_wb_strobe <= 1'b1;
                    end else begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_MEM: begin
                    if (w_timeout) begin
                        r_state <= ST_TRAP;
                        r_error <= 1'b1;
                    end else if (w_mem_done && dec_mem_write) begin
                        r_state <= ST_FETCH;
                    end else if (w_mem_done) begin
                        r_state     <= ST_WB;
                        r_wb_strobe <= 1'b1;
                    end else begin
                        r_mem_is_fetch <= 1'b0;
                    end
                end
                ST_WB: begin
                    r_state <= ST_FETCH;
                end
                ST_TRAP: begin
                    r_error <= 1'b1;
                end
                default: begin
                    r_state <= ST_TRAP;
                    r_error <= 1'b1;
                end
            endcase
        end
    end

    assign mem.mem_req      = w_mem_req;
    assign mem.mem_we       = (r_state == ST_MEM) && dec_mem_write;
    assign mem.mem_is_fetch = r_mem_is_fetch;

    assign ir_load  = (r_state == ST_FETCH) && w_mem_done;
    assign pc_write = r_wb_strobe || w_branch_done || w_store_done;
    assign retire   = r_wb_strobe || w_branch_done || w_store_done;
    assign rf_write = r_wb_strobe;
    assign error    = r_error;
    assign state    = r_state;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the RV32I core. It steps one instruction at a time through FETCH, DECODE, EXEC, MEM and WB. It drives the single shared memory port with a req/ready handshake and produces one-cycle write strobes for the IR, PC and register file. It sits between the combinational opcode decoder and the datapath: decoder outputs say *what* the instruction needs, this block says *when*.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles a memory request may wait for `mem_ready` (only with `SEQ_TIMEOUT_EN`).

Ports:
- `clk`  in  1  single clock, all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `opcode`  in  7  instruction[6:0] from the IR; valid from DECODE onward.
- `dec_mem_read`  in  1  decoder MemRead.
- `dec_mem_write`  in  1  decoder MemWrite.
- `dec_reg_write`  in  1  decoder RegWrite.
- `stall`  in  1  external hold; sampled only in FETCH before a request is issued.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request, held until accepted.
- `mem_we`  out  1  write request (store); 0 for fetch and load.
- `mem_is_fetch`  out  1  address mux select: 1 = PC, 0 = ALU result.
- `ir_load`  out  1  load the IR from memory read data.
- `pc_write`  out  1  update the PC from the next-PC mux (one pulse per instruction).
- `rf_write`  out  1  register file write enable.
- `retire`  out  1  instruction completed.
- `error`  out  1  sticky: illegal opcode or memory timeout.
- `state`  out  3  current state encoding, for debug.

## Operation
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- **RESET**: entered while `rst_n`=0. The first cycle after release is RESET, then FETCH.
- **FETCH**
  - If `stall`=1 and no request is outstanding, hold with `mem_req`=0.
  - Otherwise `mem_req`=1, `mem_is_fetch`=1, `mem_we`=0.
  - When `mem_ready`=1: `ir_load`=1 that cycle, next state DECODE.
- **DECODE**: no outputs asserted.
  - `opcode` not in the legal set: go to TRAP.
  - Otherwise go to EXEC.
- **EXEC**
  - Load/store (`dec_mem_read` or `dec_mem_write`): next state MEM.
  - Else if `dec_reg_write`=1 (R, I-imm, LUI, AUIPC, JAL): next state WB.
  - Else (branch): `pc_write`=1 and `retire`=1 this cycle, next state FETCH.
- **MEM**
  - `mem_req`=1, `mem_is_fetch`=0, `mem_we`=`dec_mem_write`.
  - On `mem_ready`=1: a load goes to WB; a store asserts `pc_write`=1 and `retire`=1 that cycle and goes to FETCH.
- **WB**: `rf_write`=1, `pc_write`=1, `retire`=1 for exactly one cycle, then FETCH.
- **TRAP**: `error`=1. All strobes and `mem_req` are 0. Only reset exits TRAP.
- Handshake rules:
  - While `mem_req`=1 and `mem_ready`=0, `mem_req`, `mem_we` and `mem_is_fetch` stay stable.
  - `mem_ready` is ignored whenever `mem_req`=0.
  - `stall` never cancels an outstanding request.
- Strobes are mutually consistent: at most one `pc_write` and one `retire` per instruction, and `rf_write` only in WB.

## Timing
- Reset values:
  - `mem_req`, `mem_we`, `ir_load`, `pc_write`, `rf_write`, `retire`, `error` are all 0.
  - `mem_is_fetch`=1.
  - `state`=RESET.
- Asserting `rst_n`=0 mid-request drops `mem_req` on the next edge. The memory must discard the request.
- Outputs are Moore-style from state, except `ir_load`, MEM-completion `pc_write`/`retire`, and `mem_we`, which are combinational from state plus `mem_ready`/decoder inputs.
- Minimum cycles per instruction with zero-wait memory (`mem_ready` high in the request cycle):
  - branch: 3
  - ALU / LUI / AUIPC / JAL: 4
  - store: 4
  - load: 5
- Each memory wait cycle adds exactly one cycle.
- `stall` and `mem_ready` arriving in the same FETCH cycle with a request already outstanding: the fetch completes.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A wait counter clears on every request issue and increments each cycle `mem_req`=1 and `mem_ready`=0.
  - When the count reaches `TIMEOUT_CYCLES`, the block drops `mem_req` and enters TRAP on the next edge, setting `error`.
  - `mem_ready` on the same edge the count reaches the limit wins: no trap.
- `SEQ_TIMEOUT_EN` undefined: no counter; the block waits indefinitely, and `error` is set only by an illegal opcode.

## Structure
- Shared package `cpu_pkg` holds:
  - the opcode constants: R 0110011, I-imm 0010011, LW 0000011, S 0100011, B 1100011, JAL 1101111, LUI 0110111, AUIPC 0010111;
  - the state enum and its 3-bit encoding;
  - the legal-opcode check function.
- The decoder uses the same opcode constants.
- One sub-module: `mem_wait_timer`, the timeout counter, instantiated only under `SEQ_TIMEOUT_EN`.

## Test plan
- **Reset and ALU instruction:** hold `rst_n`=0 for 3 cycles, release, opcode 0110011, `mem_ready` tied 1 -> RESET, FETCH, DECODE, EXEC, WB; `rf_write`, `pc_write`, `retire` pulse once, in cycle 5.
- **Load with wait states:** opcode 0000011, `mem_ready` low 2 cycles in MEM -> `mem_req` and `mem_we`=0 stable for 3 cycles; total 7 cycles; `rf_write` in WB.
- **Store:** opcode 0100011 -> `mem_we`=1 in MEM, `rf_write` never asserted, `retire` on the MEM completion cycle; total 4 cycles.
- **Branch and stall:** opcode 1100011 -> `pc_write`/`retire` in EXEC, 3 cycles. Then assert `stall` in FETCH -> `mem_req` stays 0 until `stall` drops.
- **Illegal opcode:** opcode 1111111 -> TRAP after DECODE; `error`=1; no further `mem_req`. Reset clears `error` to 0.
- **Timeout (`SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4):** `mem_ready` never asserted in FETCH -> TRAP after 4 wait cycles, `error`=1. Repeat with `mem_ready` on the 4th cycle -> no trap, DECODE follows.
